// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the fetch/memory-stage port arbiter:
//   FSM state encoding, requester IDs, default access timeout and a
//   helper that sizes the timeout counter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEM_ACC = 2'd1,
      ST_IF_ACC  = 2'd2
   } state_t;

   localparam logic REQ_IF  = 1'b0;
   localparam logic REQ_MEM = 1'b1;

   localparam int unsigned DEFAULT_TIMEOUT_CYC = 32'd255;

   // Bits needed to hold 0..cyc.
   function automatic int unsigned timeout_w(input int unsigned cyc);
      return $clog2(cyc + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// mem_timeout_counter
//   Counts cycles an external access has been outstanding.
//   Ports:
//     clk      clock
//     rst      synchronous active-high reset
//     clear    zero the count (idle or access acknowledged)
//     count_en access outstanding this cycle without an ack
//     expired  combinational: this is the LIMIT-th outstanding cycle,
//              so the access is aborted at the coming edge
module mem_timeout_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned LIMIT = DEFAULT_TIMEOUT_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int unsigned W = timeout_w(LIMIT);
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] count;

   // Expiring on LIMIT-1 keeps the request asserted for exactly LIMIT cycles.
   assign expired = count_en & (count == LAST);

   always_ff @(posedge clk) begin
      if (rst || clear || expired) begin
         count <= '0;
      end else if (count_en) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single-ported external memory between instruction fetch and
//   the memory stage. Memory-stage accesses go first (older instruction).
//   stall_o holds the whole pipeline until every access requested in the
//   current pipeline cycle has completed or timed out.
//   Ports:
//     clk_i, rst_i                   clock, synchronous active-high reset
//     if_req_i/if_addr_i/if_data_o   fetch request, PC, registered instruction
//     mem_rd_i/mem_wr_i/mem_addr_i/
//     mem_wdata_i/mem_rdata_o        load/store request, registered load data
//     stall_o                        freeze PC and pipeline registers
//     ext_req_o/ext_we_o/ext_addr_o/
//     ext_wdata_o/ext_rdata_i/
//     ext_ack_i                      external memory handshake
//     err_o                          sticky access-timeout flag
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_data_o,
   input  logic              mem_rd_i,
   input  logic              mem_wr_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic              stall_o,
   output logic              ext_req_o,
   output logic              ext_we_o,
   output logic [ADDR_W-1:0] ext_addr_o,
   output logic [DATA_W-1:0] ext_wdata_o,
   input  logic [DATA_W-1:0] ext_rdata_i,
   input  logic              ext_ack_i,
   output logic              err_o
);

   state_t            state, state_next;
   logic              done_if, done_if_next;
   logic              done_mem, done_mem_next;
   logic              req_next, we_next, err_next;
   logic [ADDR_W-1:0] addr_next;
   logic [DATA_W-1:0] wdata_next, if_data_next, mem_rdata_next;
   logic              mem_pend, if_pend;
   logic              acc_active, expired, target;

   assign mem_pend   = (mem_rd_i | mem_wr_i) & ~done_mem;
   assign if_pend    = if_req_i & ~done_if;
   assign stall_o    = mem_pend | if_pend;
   assign acc_active = (state != ST_IDLE);
   assign target     = (state == ST_MEM_ACC) ? REQ_MEM : REQ_IF;

   mem_timeout_counter #(
      .LIMIT (TIMEOUT_CYC)
   ) u_timeout (
      .clk      (clk_i),
      .rst      (rst_i),
      .clear    (~acc_active | ext_ack_i),
      .count_en (acc_active & ~ext_ack_i),
      .expired  (expired)
   );

   always_comb begin
      state_next     = state;
      done_if_next   = done_if;
      done_mem_next  = done_mem;
      req_next       = ext_req_o;
      we_next        = ext_we_o;
      addr_next      = ext_addr_o;
      wdata_next     = ext_wdata_o;
      if_data_next   = if_data_o;
      mem_rdata_next = mem_rdata_o;
      err_next       = err_o;

      case (state)
         ST_IDLE: begin
            if (mem_pend) begin
               state_next = ST_MEM_ACC;
               req_next   = 1'b1;
               we_next    = mem_wr_i;
               addr_next  = mem_addr_i;
               wdata_next = mem_wdata_i;
            end else if (if_pend) begin
               state_next = ST_IF_ACC;
               req_next   = 1'b1;
               we_next    = 1'b0;
               addr_next  = if_addr_i;
               wdata_next = '0;
            end else begin
               // Nothing pending means stall_o is low: the pipeline advances
               // on this edge, so the next cycle's accesses start fresh.
               done_if_next  = 1'b0;
               done_mem_next = 1'b0;
            end
         end

         ST_MEM_ACC, ST_IF_ACC: begin
            // An aborted access completes like an acked one, with zero data.
            if (ext_ack_i || expired) begin
               state_next = ST_IDLE;
               req_next   = 1'b0;
               we_next    = 1'b0;
               if (target == REQ_MEM) begin
                  done_mem_next = 1'b1;
                  if (!ext_we_o) begin
                     mem_rdata_next = ext_ack_i ? ext_rdata_i : '0;
                  end
               end else begin
                  done_if_next = 1'b1;
                  if_data_next = ext_ack_i ? ext_rdata_i : '0;
               end
               if (!ext_ack_i) begin
                  err_next = 1'b1;
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
            req_next   = 1'b0;
            we_next    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         done_if     <= 1'b0;
         done_mem    <= 1'b0;
         ext_req_o   <= 1'b0;
         ext_we_o    <= 1'b0;
         ext_addr_o  <= '0;
         ext_wdata_o <= '0;
         if_data_o   <= '0;
         mem_rdata_o <= '0;
         err_o       <= 1'b0;
      end else begin
         state       <= state_next;
         done_if     <= done_if_next;
         done_mem    <= done_mem_next;
         ext_req_o   <= req_next;
         ext_we_o    <= we_next;
         ext_addr_o  <= addr_next;
         ext_wdata_o <= wdata_next;
         if_data_o   <= if_data_next;
         mem_rdata_o <= mem_rdata_next;
         err_o       <= err_next;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a queue-driven memory model,
//   an access scoreboard and a pipeline-cycle completion scoreboard.
module tb_mem_port_arbiter;

   localparam int unsigned TO = 8;

   logic        clk;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_data_o;
   logic        mem_rd_i;
   logic        mem_wr_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic [31:0] mem_rdata_o;
   logic        stall_o;
   logic        ext_req_o;
   logic        ext_we_o;
   logic [31:0] ext_addr_o;
   logic [31:0] ext_wdata_o;
   logic [31:0] ext_rdata_i;
   logic        ext_ack_i;
   logic        err_o;

   mem_port_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_data_o   (if_data_o),
      .mem_rd_i    (mem_rd_i),
      .mem_wr_i    (mem_wr_i),
      .mem_addr_i  (mem_addr_i),
      .mem_wdata_i (mem_wdata_i),
      .mem_rdata_o (mem_rdata_o),
      .stall_o     (stall_o),
      .ext_req_o   (ext_req_o),
      .ext_we_o    (ext_we_o),
      .ext_addr_o  (ext_addr_o),
      .ext_wdata_o (ext_wdata_o),
      .ext_rdata_i (ext_rdata_i),
      .ext_ack_i   (ext_ack_i),
      .err_o       (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      int          len;
   } acc_t;

   typedef struct {
      int          stalls;
      logic [31:0] ifd;
      logic [31:0] memd;
      logic        err;
   } cyc_t;

   typedef struct {
      int          wait_cyc;
      logic [31:0] data;
   } mresp_t;

   acc_t   exp_acc[$];
   cyc_t   exp_cyc[$];
   mresp_t mem_q[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory model: each new request pops a response; wait_cyc < 0 never acks.
   initial begin
      mresp_t cur;
      int     seen;
      logic   active;
      ext_ack_i   = 1'b0;
      ext_rdata_i = 32'h5A5A5A5A;
      active      = 1'b0;
      seen        = 0;
      cur.wait_cyc = -1;
      cur.data     = '0;
      forever begin
         @(posedge clk);
         #1;
         if (ext_req_o) begin
            if (!active) begin
               active = 1'b1;
               seen   = 0;
               if (mem_q.size() > 0) cur = mem_q.pop_front();
               else begin
                  cur.wait_cyc = -1;
                  cur.data     = '0;
               end
            end
            ext_ack_i   = (cur.wait_cyc >= 0) && (seen == cur.wait_cyc);
            ext_rdata_i = ext_ack_i ? cur.data : 32'h5A5A5A5A;
            seen++;
         end else begin
            active      = 1'b0;
            ext_ack_i   = 1'b0;
            ext_rdata_i = 32'h5A5A5A5A;
         end
      end
   end

   // Access monitor: every external request must match the next expected
   // access, hold its fields while asserted and last the expected cycles.
   initial begin
      acc_t cur;
      logic prev_req;
      logic have;
      int   len;
      prev_req = 1'b0;
      have     = 1'b0;
      len      = 0;
      forever begin
         @(negedge clk);
         if (ext_req_o) begin
            if (!prev_req) begin
               len = 0;
               if (exp_acc.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL acc_unexpected: got access to %h expected none", ext_addr_o);
                  have = 1'b0;
               end else begin
                  cur  = exp_acc.pop_front();
                  have = 1'b1;
               end
            end
            len++;
            if (have) begin
               chk("acc_addr", ext_addr_o, cur.addr);
               chk("acc_we", {31'b0, ext_we_o}, {31'b0, cur.we});
               if (cur.we) chk("acc_wdata", ext_wdata_o, cur.wdata);
            end
         end else if (prev_req && have) begin
            chk("acc_len", 32'(len), 32'(cur.len));
            have = 1'b0;
         end
         prev_req = ext_req_o;
      end
   end

   // Completion monitor: when the pipeline advances with work requested,
   // compare stall length and returned data against the expected cycle.
   initial begin
      cyc_t c;
      int   run;
      run = 0;
      forever begin
         @(negedge clk);
         if (stall_o) begin
            run++;
         end else begin
            if (if_req_i || mem_rd_i || mem_wr_i) begin
               if (exp_cyc.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL cyc_unexpected: got completion expected none at %0t", $time);
               end else begin
                  c = exp_cyc.pop_front();
                  chk("cyc_stalls", 32'(run), 32'(c.stalls));
                  chk("cyc_if_data", if_data_o, c.ifd);
                  chk("cyc_mem_rdata", mem_rdata_o, c.memd);
                  chk("cyc_err", {31'b0, err_o}, {31'b0, c.err});
               end
            end
            run = 0;
         end
      end
   end

   task automatic push_mem(input int w, input logic [31:0] d);
      mresp_t m;
      m.wait_cyc = w;
      m.data     = d;
      mem_q.push_back(m);
   endtask

   task automatic push_acc(input logic [31:0] a, input logic we, input logic [31:0] wd, input int len);
      acc_t x;
      x.addr  = a;
      x.we    = we;
      x.wdata = wd;
      x.len   = len;
      exp_acc.push_back(x);
   endtask

   task automatic push_cyc(input int st, input logic [31:0] ifd, input logic [31:0] md, input logic e);
      cyc_t x;
      x.stalls = st;
      x.ifd    = ifd;
      x.memd   = md;
      x.err    = e;
      exp_cyc.push_back(x);
   endtask

   task automatic drive(input logic ifr, input logic [31:0] ia, input logic rd, input logic wr,
                        input logic [31:0] ma, input logic [31:0] wd);
      if_req_i    = ifr;
      if_addr_i   = ia;
      mem_rd_i    = rd;
      mem_wr_i    = wr;
      mem_addr_i  = ma;
      mem_wdata_i = wd;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (stall_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (stall_o) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got stall_o 1 after %0d cycles expected 0", name, n);
      end
   endtask

   task automatic finish_cycle(input string name);
      wait_done(name);
      next_cycle();
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
      next_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200000");
      $fatal(1);
   end

   initial begin
      int n;
      rst_i = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      chk("rst_ext_req", {31'b0, ext_req_o}, 32'd0);
      chk("rst_ext_we", {31'b0, ext_we_o}, 32'd0);
      chk("rst_ext_addr", ext_addr_o, 32'd0);
      chk("rst_ext_wdata", ext_wdata_o, 32'd0);
      chk("rst_if_data", if_data_o, 32'd0);
      chk("rst_mem_rdata", mem_rdata_o, 32'd0);
      chk("rst_err", {31'b0, err_o}, 32'd0);
      chk("rst_stall", {31'b0, stall_o}, 32'd0);
      next_cycle();

      // Fetch only, zero-wait memory.
      push_mem(0, 32'h8C220004);
      push_acc(32'h10, 1'b0, '0, 1);
      push_cyc(2, 32'h8C220004, 32'h0, 1'b0);
      drive(1'b1, 32'h10, 1'b0, 1'b0, '0, '0);
      finish_cycle("fetch");

      // Load and fetch in the same pipeline cycle: load first.
      push_mem(0, 32'hCAFEF00D);
      push_mem(0, 32'h00221820);
      push_acc(32'h40, 1'b0, '0, 1);
      push_acc(32'h14, 1'b0, '0, 1);
      push_cyc(4, 32'h00221820, 32'hCAFEF00D, 1'b0);
      drive(1'b1, 32'h14, 1'b1, 1'b0, 32'h40, '0);
      finish_cycle("load_fetch");

      // Store with 3 wait states; read data must not disturb mem_rdata_o.
      push_mem(3, 32'h77777777);
      push_acc(32'h80, 1'b1, 32'hDEADBEEF, 4);
      push_cyc(5, 32'h00221820, 32'hCAFEF00D, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF);
      finish_cycle("store");

      // Read and write both set behaves as a write.
      push_mem(0, 32'h66666666);
      push_acc(32'h84, 1'b1, 32'h0BADF00D, 1);
      push_cyc(2, 32'h00221820, 32'hCAFEF00D, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b1, 32'h84, 32'h0BADF00D);
      finish_cycle("rd_wr");

      // Back-to-back fetches across a pipeline advance.
      push_mem(0, 32'h20080005);
      push_mem(0, 32'h2009000A);
      push_acc(32'h0, 1'b0, '0, 1);
      push_acc(32'h4, 1'b0, '0, 1);
      push_cyc(2, 32'h20080005, 32'hCAFEF00D, 1'b0);
      push_cyc(2, 32'h2009000A, 32'hCAFEF00D, 1'b0);
      drive(1'b1, 32'h0, 1'b0, 1'b0, '0, '0);
      wait_done("b2b_first");
      next_cycle();
      drive(1'b1, 32'h4, 1'b0, 1'b0, '0, '0);
      finish_cycle("b2b_second");

      // Fetch that is never acknowledged: abort after TO cycles.
      push_mem(-1, 32'h0);
      push_acc(32'h8, 1'b0, '0, TO);
      push_cyc(TO + 1, 32'h0, 32'hCAFEF00D, 1'b1);
      drive(1'b1, 32'h8, 1'b0, 1'b0, '0, '0);
      finish_cycle("timeout");

      // Error flag stays set across a later good access.
      push_mem(1, 32'h12345678);
      push_acc(32'h18, 1'b0, '0, 2);
      push_cyc(3, 32'h12345678, 32'hCAFEF00D, 1'b1);
      drive(1'b1, 32'h18, 1'b0, 1'b0, '0, '0);
      finish_cycle("sticky");

      // Reset during a load, with the ack landing in the reset cycle.
      push_mem(2, 32'hBAD0BAD0);
      push_mem(0, 32'h11223344);
      push_acc(32'h100, 1'b0, '0, 3);
      push_acc(32'h100, 1'b0, '0, 1);
      push_cyc(6, 32'h0, 32'h11223344, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0, 32'h100, '0);
      n = 0;
      @(negedge clk);
      while (!ext_req_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rstmid_req_seen", {31'b0, ext_req_o}, 32'd1);
      next_cycle();
      next_cycle();
      rst_i = 1'b1;
      next_cycle();
      rst_i = 1'b0;
      @(negedge clk);
      chk("rstmid_ext_req", {31'b0, ext_req_o}, 32'd0);
      chk("rstmid_mem_rdata", mem_rdata_o, 32'd0);
      chk("rstmid_if_data", if_data_o, 32'd0);
      chk("rstmid_err", {31'b0, err_o}, 32'd0);
      chk("rstmid_stall", {31'b0, stall_o}, 32'd1);
      finish_cycle("rst_mid");

      repeat (3) next_cycle();
      chk("left_acc", 32'(exp_acc.size()), 32'd0);
      chk("left_cyc", 32'(exp_cyc.size()), 32'd0);
      chk("left_mem", 32'(mem_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external single-ported memory between the fetch stage (instruction reads) and the memory stage (loads/stores) of the 5-stage pipeline.
- Sequences each access through a req/ack handshake.
- Returns read data to the requesting stage.
- Drives a global stall that freezes PC, IF_ID, ID_EX, EX_MEM and MEM_WB until every access in the current pipeline cycle has completed.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 255, maximum cycles to wait for ext_ack_i before aborting an access.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- if_req_i  in  1  fetch stage requests instruction read.
- if_addr_i  in  ADDR_W  fetch address (PC).
- if_data_o  out  DATA_W  fetched instruction (registered).
- mem_rd_i  in  1  MemRead from EX_MEM.
- mem_wr_i  in  1  MemWrite from EX_MEM.
- mem_addr_i  in  ADDR_W  ALU result from EX_MEM.
- mem_wdata_i  in  DATA_W  store data from EX_MEM.
- mem_rdata_o  out  DATA_W  load data to MEM_WB (registered).
- stall_o  out  1  freeze all pipeline registers and PC.
- ext_req_o  out  1  external access request.
- ext_we_o  out  1  external write enable.
- ext_addr_o  out  ADDR_W  external address.
- ext_wdata_o  out  DATA_W  external write data.
- ext_rdata_i  in  DATA_W  external read data, valid with ext_ack_i.
- ext_ack_i  in  1  one-cycle completion pulse.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset values: state IDLE; ext_req_o, ext_we_o, ext_addr_o, ext_wdata_o = 0; if_data_o, mem_rdata_o = 0; done_if, done_mem = 0; timeout counter = 0; err_o = 0.
- Pending work:
  - mem_pend = (mem_rd_i | mem_wr_i) & !done_mem.
  - if_pend = if_req_i & !done_if.
  - stall_o = mem_pend | if_pend (combinational).
- Stage inputs must stay stable while stall_o = 1; the pipeline guarantees this by freezing.
- FSM states: IDLE, MEM_ACC, IF_ACC.
- IDLE:
  - If mem_pend, go to MEM_ACC. The memory stage has priority because it holds the older instruction.
  - Else if if_pend, go to IF_ACC.
  - On entry to an ACC state, register ext_req_o = 1 with addr/we/wdata. ext_we_o = mem_wr_i for MEM_ACC, 0 for IF_ACC.
- ACC states:
  - Hold ext_req_o and all ext_* outputs stable until ext_ack_i = 1.
  - On ack: capture ext_rdata_i into mem_rdata_o (loads only; stores leave it unchanged) or into if_data_o; set done_mem or done_if; drop ext_req_o; return to IDLE.
  - A second access therefore starts no earlier than the cycle after the ack.
- Cycle closure: when stall_o = 0 at a clock edge, clear done_if and done_mem at that edge. The pipeline advances on the same edge.
- Latency: minimum of 2 stall cycles per access with a zero-wait memory (ack in the first cycle of ext_req_o).
  - A cycle needing both a fetch and a load/store costs at least 4 stall cycles.
- mem_rd_i and mem_wr_i both high: treated as a write.
- Timeout:
  - The counter increments each cycle in an ACC state and clears on ack or in IDLE.
  - When it reaches TIMEOUT_CYC without an ack: abort, drop ext_req_o, load 0 into the target data register, set the done flag, set err_o (sticky until reset), return to IDLE.
- ext_ack_i in IDLE is ignored.
- Reset mid-access: at the reset edge, return to IDLE and drop ext_req_o the following cycle. An ack arriving while rst_i = 1 is ignored. The done flags clear, so the pending access restarts after reset.
- No requests: stall_o = 0 and the FSM stays in IDLE.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE, MEM_ACC, IF_ACC, 2-bit localparams);
  - requester ID constants (REQ_IF = 0, REQ_MEM = 1);
  - the default TIMEOUT_CYC.
- One natural sub-module: mem_timeout_counter (load/clear/expire, width clog2(TIMEOUT_CYC+1)).

Test Plan:
- Fetch only:
  - Stimulus: if_req_i = 1, if_addr_i = 0x00000010, memory acks 1 cycle after request with 0x8C220004.
  - Response: stall_o high 2 cycles, if_data_o = 0x8C220004, ext_we_o = 0 throughout.
- Load + fetch same cycle:
  - Stimulus: mem_rd_i = 1, addr 0x40; if_req_i = 1, addr 0x14; zero-wait memory.
  - Response: first ext access uses addr 0x40 and the second 0x14; stall_o high 4 cycles; mem_rdata_o and if_data_o both updated.
- Store:
  - Stimulus: mem_wr_i = 1, addr 0x80, wdata 0xDEADBEEF; 3 wait states.
  - Response: ext_we_o = 1 and ext_addr_o/ext_wdata_o stable for 4 cycles; mem_rdata_o unchanged.
- Timeout (TIMEOUT_CYC = 8):
  - Stimulus: fetch with ext_ack_i never asserted.
  - Response: ext_req_o drops after 8 cycles, if_data_o = 0, err_o = 1 and remains 1.
- Reset mid-access:
  - Stimulus: rst_i pulsed during MEM_ACC, ack asserted in the same cycle.
  - Response: ack ignored, all outputs return to reset values, access re-issued after reset.
- Back-to-back cycles:
  - Stimulus: two consecutive fetches 0x0 then 0x4.
  - Response: done flags clear on the stall_o = 0 edge and the second fetch issues correctly.
